// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and a busy flag for stall logic
module mdu_hilo #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int unsigned MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW = $clog2(MAXC + 1);
  localparam logic [0:0] IDLE = 1'b0, RUN = 1'b1;
  localparam logic [2:0] OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3, OP_DIVU = 3'd4,
                         OP_MTHI = 3'd5, OP_MTLO = 3'd6;
  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    op_q;
  logic [31:0]   a_q, b_q;
  logic          is_mul, sgn_m, sgn_d, wr;
  logic [63:0]   am, bm, prod, res;
  logic [31:0]   ua, ub, q, r;
  // Result is formed combinationally from the latched operands and committed on the last busy edge
  always_comb begin
    is_mul = op_q == OP_MULT || op_q == OP_MULTU;
    sgn_m  = op_q == OP_MULT;
    sgn_d  = op_q == OP_DIV;
    am     = {{32{sgn_m & a_q[31]}}, a_q};
    bm     = {{32{sgn_m & b_q[31]}}, b_q};
    prod   = am * bm;
    ua     = sgn_d && a_q[31] ? -a_q : a_q;
    ub     = sgn_d && b_q[31] ? -b_q : b_q;
    q      = ub == 32'd0 ? 32'd0 : ua / ub;
    r      = ub == 32'd0 ? 32'd0 : ua % ub;
    res    = is_mul ? prod
                    : {sgn_d && a_q[31] ? -r : r, sgn_d && (a_q[31] ^ b_q[31]) ? -q : q};
    wr     = is_mul || b_q != 32'd0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (state == IDLE) begin
      if (start && op >= OP_MULT && op <= OP_DIVU) begin
        state <= RUN;
        op_q  <= op;
        a_q   <= a;
        b_q   <= b;
        cnt   <= op <= OP_MULTU ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      end else if (start && op == OP_MTHI) begin
        hi <= a;
      end else if (start && op == OP_MTLO) begin
        lo <= a;
      end
    end else begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state <= IDLE;
        if (wr) {hi, lo} <= res;
      end
    end
  end
  assign busy = state == RUN;
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed checks of mdu_hilo timing, arithmetic, ignored requests and async reset
module tb_mdu_hilo;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy;
  logic [31:0] hi, lo;
  int          passed = 0, total = 0;

  mdu_hilo dut (.clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
                .busy(busy), .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive a request for exactly one edge; called at a negedge, returns at the next negedge
  task automatic go(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
  endtask

  task automatic run(input string tag, input int n, input logic [31:0] ohi, input logic [31:0] olo,
                     input logic [31:0] nhi, input logic [31:0] nlo);
    for (int i = 0; i < n; i++) begin
      chk({tag, " busy"}, {31'd0, busy}, 32'd1);
      chk({tag, " hold hi"}, hi, ohi);
      chk({tag, " hold lo"}, lo, olo);
      @(negedge clk);
    end
    chk({tag, " busy end"}, {31'd0, busy}, 32'd0);
    chk({tag, " hi"}, hi, nhi);
    chk({tag, " lo"}, lo, nlo);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    go(3'd1, 32'hFFFFFFFE, 32'd3);
    run("mult", 5, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFA);
    go(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run("multu", 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 32'hFFFFFFFE, 32'h00000001);
    go(3'd3, 32'hFFFFFFF9, 32'd2);
    run("div", 10, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFD);
    go(3'd4, 32'd7, 32'd2);
    run("divu", 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd1, 32'd3);
    go(3'd5, 32'h1234, 32'd0);
    chk("mthi busy", {31'd0, busy}, 32'd0);
    chk("mthi hi", hi, 32'h1234);
    chk("mthi lo", lo, 32'd3);
    go(3'd6, 32'h5678, 32'd0);
    chk("mtlo busy", {31'd0, busy}, 32'd0);
    chk("mtlo hi", hi, 32'h1234);
    chk("mtlo lo", lo, 32'h5678);
    go(3'd7, 32'h9999, 32'd1);
    chk("nop busy", {31'd0, busy}, 32'd0);
    chk("nop hi", hi, 32'h1234);
    go(3'd3, 32'd5, 32'd0);
    run("div0", 10, 32'h1234, 32'h5678, 32'h1234, 32'h5678);
    go(3'd3, 32'h80000000, 32'hFFFFFFFF);
    run("divovf", 10, 32'h1234, 32'h5678, 32'd0, 32'h80000000);
    // Requests issued while busy must be dropped without disturbing the count
    go(3'd3, 32'd100, 32'd7);
    for (int i = 0; i < 10; i++) begin
      chk("ign busy", {31'd0, busy}, 32'd1);
      chk("ign hi", hi, 32'd0);
      chk("ign lo", lo, 32'h80000000);
      start = (i == 2 || i == 4);
      op = i == 2 ? 3'd6 : i == 4 ? 3'd1 : 3'd0;
      a = i == 2 ? 32'hDEAD : 32'd3;
      b = 32'd4;
      @(negedge clk);
    end
    start = 1'b0; op = 3'd0;
    chk("ign busy end", {31'd0, busy}, 32'd0);
    chk("ign hi", hi, 32'd2);
    chk("ign lo", lo, 32'd14);
    go(3'd1, 32'hFFFFFFFF, 32'd6);
    run("b2b mult", 5, 32'd2, 32'd14, 32'hFFFFFFFF, 32'hFFFFFFFA);
    go(3'd3, 32'd9, 32'd2);
    repeat (2) @(negedge clk);
    chk("pre-rst busy", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async busy", {31'd0, busy}, 32'd0);
    chk("async hi", hi, 32'd0);
    chk("async lo", lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post-rst busy", {31'd0, busy}, 32'd0);
    chk("post-rst hi", hi, 32'd0);
    chk("post-rst lo", lo, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
